// File: rtl/ttt_prog_sequencer.sv
// Replays a byte-framed host program stream (OP, NID, CNT, D...) as single-cycle
// neuron programming writes. Optional trailing XOR checksum byte: define PROG_CHECKSUM_EN.
module ttt_prog_sequencer #(
  parameter int NUM_PROCESSORS = 10,
  parameter int PROG_WIDTH     = 8,
  localparam int NID_W         = (NUM_PROCESSORS > 1) ? $clog2(NUM_PROCESSORS) : 1
) (
  input  logic                  clock_fast,
  input  logic                  reset,
  input  logic [PROG_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [NID_W-1:0]      neuron_id,
  output logic [2:0]            prog_header,
  output logic [PROG_WIDTH-1:0] prog_data,
  output logic                  hold,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_NID,
    S_CNT,
    S_DATA,
    S_CHK,
    S_DONE
  } state_t;

  // Only AUTO_INC (bit 7) and the header field (bits 2:0) may be set in OP.
  localparam logic [PROG_WIDTH-1:0] OP_LEGAL  = PROG_WIDTH'(8'h87);
  localparam logic [PROG_WIDTH-1:0] NID_LIMIT = PROG_WIDTH'(NUM_PROCESSORS);
  localparam logic [NID_W-1:0]      NID_LAST  = NID_W'(NUM_PROCESSORS - 1);

  state_t                  state_reg;
  logic [2:0]              hdr_reg;
  logic                    auto_inc_reg;
  logic [NID_W-1:0]        cur_reg;
  logic [PROG_WIDTH-1:0]   rem_reg;
  logic [NID_W-1:0]        neuron_id_reg;
  logic [2:0]              prog_header_reg;
  logic [PROG_WIDTH-1:0]   prog_data_reg;
  logic                    busy_reg;
  logic                    done_reg;
  logic                    err_reg;
`ifdef PROG_CHECKSUM_EN
  logic [PROG_WIDTH-1:0]   chk_reg;
`endif

  logic                    accept;
  logic                    op_ok;
  logic                    nid_ok;
  logic                    cnt_ok;
  logic [NID_W-1:0]        cur_next;

  assign in_ready = !reset && (state_reg != S_DONE);
  assign accept   = in_valid && in_ready;

  assign op_ok  = (in_data[2:0] != 3'b000) && ((in_data & ~OP_LEGAL) == '0);
  assign nid_ok = (in_data < NID_LIMIT);
  assign cnt_ok = (in_data != '0);

  // Target for the write after the current one; wraps at the last neuron.
  assign cur_next = !auto_inc_reg       ? cur_reg :
                    (cur_reg == NID_LAST) ? '0 : cur_reg + NID_W'(1);

  always_ff @(posedge clock_fast) begin
    if (reset) begin
      state_reg       <= S_IDLE;
      hdr_reg         <= '0;
      auto_inc_reg    <= 1'b0;
      cur_reg         <= '0;
      rem_reg         <= '0;
      neuron_id_reg   <= '0;
      prog_header_reg <= '0;
      prog_data_reg   <= '0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      err_reg         <= 1'b0;
`ifdef PROG_CHECKSUM_EN
      chk_reg         <= '0;
`endif
    end else begin
      prog_header_reg <= 3'b000;
      done_reg        <= 1'b0;
      // busy drops one cycle after done; an OP accepted this cycle re-asserts it below.
      if (done_reg) busy_reg <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            if (op_ok) begin
              hdr_reg      <= in_data[2:0];
              auto_inc_reg <= in_data[7];
              busy_reg     <= 1'b1;
              state_reg    <= S_NID;
`ifdef PROG_CHECKSUM_EN
              chk_reg      <= in_data;
`endif
            end else begin
              err_reg <= 1'b1;
            end
          end
        end
        S_NID: begin
          if (accept) begin
            if (nid_ok) begin
              cur_reg   <= in_data[NID_W-1:0];
              state_reg <= S_CNT;
`ifdef PROG_CHECKSUM_EN
              chk_reg   <= chk_reg ^ in_data;
`endif
            end else begin
              err_reg   <= 1'b1;
              busy_reg  <= 1'b0;
              state_reg <= S_IDLE;
            end
          end
        end
        S_CNT: begin
          if (accept) begin
            if (cnt_ok) begin
              rem_reg   <= in_data;
              state_reg <= S_DATA;
`ifdef PROG_CHECKSUM_EN
              chk_reg   <= chk_reg ^ in_data;
`endif
            end else begin
              err_reg   <= 1'b1;
              busy_reg  <= 1'b0;
              state_reg <= S_IDLE;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            prog_header_reg <= hdr_reg;
            prog_data_reg   <= in_data;
            neuron_id_reg   <= cur_reg;
            cur_reg         <= cur_next;
            rem_reg         <= rem_reg - PROG_WIDTH'(1);
`ifdef PROG_CHECKSUM_EN
            chk_reg         <= chk_reg ^ in_data;
            if (rem_reg == PROG_WIDTH'(1)) state_reg <= S_CHK;
`else
            if (rem_reg == PROG_WIDTH'(1)) state_reg <= S_DONE;
`endif
          end
        end
`ifdef PROG_CHECKSUM_EN
        S_CHK: begin
          if (accept) begin
            if (in_data == chk_reg) begin
              state_reg <= S_DONE;
            end else begin
              err_reg   <= 1'b1;
              busy_reg  <= 1'b0;
              state_reg <= S_IDLE;
            end
          end
        end
`endif
        S_DONE: begin
          done_reg  <= 1'b1;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign neuron_id   = neuron_id_reg;
  assign prog_header = prog_header_reg;
  assign prog_data   = prog_data_reg;
  assign hold        = busy_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign err         = err_reg;

endmodule

// File: tb/tb_ttt_prog_sequencer.sv
// Bench for ttt_prog_sequencer: directed frames plus random frames checked against a
// frame-level model (expected writes derived from OP/NID/CNT rules with plain arithmetic).
module tb_ttt_prog_sequencer;

  localparam int N  = 10;
  localparam int PW = 8;
  localparam int NW = $clog2(N);

  typedef logic [7:0] bq_t[$];

  logic          clock_fast = 1'b0;
  logic          reset;
  logic [PW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [NW-1:0] neuron_id;
  logic [2:0]    prog_header;
  logic [PW-1:0] prog_data;
  logic          hold;
  logic          busy;
  logic          done;
  logic          err;

  int checks = 0;
  int errors = 0;
  logic          err_m;
  logic [NW-1:0] last_nid_m;

  ttt_prog_sequencer #(.NUM_PROCESSORS(N), .PROG_WIDTH(PW)) dut (
    .clock_fast (clock_fast),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .neuron_id  (neuron_id),
    .prog_header(prog_header),
    .prog_data  (prog_data),
    .hold       (hold),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clock_fast = ~clock_fast;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of input, return 1 time unit after the edge that samples it.
  task automatic step(input logic v, input logic [7:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clock_fast);
    #1;
  endtask

  function automatic bq_t make_frame(input logic [7:0] op, input logic [7:0] nid,
                                     input logic [7:0] cnt, input bq_t d, input bit bad_chk);
    bq_t f;
    logic [7:0] x;
    f = '{op, nid, cnt};
    x = op ^ nid ^ cnt;
    foreach (d[i]) begin
      f.push_back(d[i]);
      x ^= d[i];
    end
`ifdef PROG_CHECKSUM_EN
    f.push_back(bad_chk ? ~x : x);
`else
    if (bad_chk) x = '0;
`endif
    return f;
  endfunction

  task automatic run_frame(input bq_t f, input int gmin, input int gmax);
    logic [7:0] op, nid, cnt, x;
    int nexp, g;
    chk("idle_ready", 32'(in_ready), 1);
    op = f[0];
    step(1'b1, op);
    if (op[2:0] == 3'd0 || op[6:3] != 4'd0) begin
      err_m = 1'b1;
      chk("op_err", 32'(err), 32'(err_m));
      chk("op_hold", 32'(hold), 0);
      chk("op_nowrite", 32'(prog_header), 0);
      return;
    end
    chk("op_hold", 32'(hold), 1);
    chk("op_busy", 32'(busy), 1);
    nid = f[1];
    step(1'b1, nid);
    if (int'(nid) >= N) begin
      err_m = 1'b1;
      chk("nid_err", 32'(err), 1);
      chk("nid_hold", 32'(hold), 0);
      chk("nid_nowrite", 32'(prog_header), 0);
      return;
    end
    chk("nid_hold", 32'(hold), 1);
    cnt = f[2];
    step(1'b1, cnt);
    if (cnt == 8'd0) begin
      err_m = 1'b1;
      chk("cnt_err", 32'(err), 1);
      chk("cnt_hold", 32'(hold), 0);
      chk("cnt_nowrite", 32'(prog_header), 0);
      return;
    end
    x = op ^ nid ^ cnt;
    for (int k = 0; k < int'(cnt); k++) begin
      g = $urandom_range(gmax, gmin);
      for (int j = 0; j < g; j++) begin
        step(1'b0, 8'($urandom));
        chk("gap_nowrite", 32'(prog_header), 0);
        chk("gap_nid", 32'(neuron_id), 32'(last_nid_m));
        chk("gap_hold", 32'(hold), 1);
      end
      step(1'b1, f[3 + k]);
      x ^= f[3 + k];
      nexp = (int'(nid) + (op[7] ? k : 0)) % N;
      chk("wr_hdr", 32'(prog_header), 32'(op[2:0]));
      chk("wr_data", 32'(prog_data), 32'(f[3 + k]));
      chk("wr_nid", 32'(neuron_id), 32'(nexp));
      last_nid_m = NW'(nexp);
    end
`ifdef PROG_CHECKSUM_EN
    step(1'b1, f[3 + int'(cnt)]);
    chk("chk_nowrite", 32'(prog_header), 0);
    if (f[3 + int'(cnt)] !== x) begin
      err_m = 1'b1;
      chk("chk_err", 32'(err), 1);
      chk("chk_hold", 32'(hold), 0);
      step(1'b0, 8'h00);
      chk("chk_nodone", 32'(done), 0);
      return;
    end
`endif
    chk("done_ready", 32'(in_ready), 0);
    chk("frame_err", 32'(err), 32'(err_m));
    step(1'b0, 8'h00);
    chk("done_pulse", 32'(done), 1);
    chk("done_hold", 32'(hold), 1);
    chk("done_nowrite", 32'(prog_header), 0);
    step(1'b0, 8'h00);
    chk("done_clear", 32'(done), 0);
    chk("hold_fall", 32'(hold), 0);
    chk("busy_fall", 32'(busy), 0);
    chk("post_ready", 32'(in_ready), 1);
  endtask

  initial begin
    bq_t q, d;
    logic [7:0] op, nid, cnt;
    bit bad;
    int r;

    // Reset held two cycles
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    step(1'b1, 8'h83);
    step(1'b1, 8'h08);
    chk("rst_nid", 32'(neuron_id), 0);
    chk("rst_hdr", 32'(prog_header), 0);
    chk("rst_data", 32'(prog_data), 0);
    chk("rst_hold", 32'(hold), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_ready", 32'(in_ready), 0);
    reset = 1'b0;
    err_m = 1'b0;
    last_nid_m = '0;
    step(1'b0, 8'h00);
    chk("rel_ready", 32'(in_ready), 1);

    // Auto-increment wrap, back-to-back
    d = '{8'h11, 8'h22, 8'h33};
    run_frame(make_frame(8'h83, 8'h08, 8'h03, d, 1'b0), 0, 0);

    // Two-cycle gaps, fixed neuron
    d = '{8'hAA, 8'hBB};
    run_frame(make_frame(8'h02, 8'h04, 8'h02, d, 1'b0), 2, 2);

    // Bad OP, then bad NID, then a valid frame
    q = '{8'h00};
    run_frame(q, 0, 0);
    q = '{8'h01, 8'h0A};
    run_frame(q, 0, 0);
    d = '{8'h5C};
    run_frame(make_frame(8'h05, 8'h09, 8'h01, d, 1'b0), 0, 1);

    // Reset after the first data byte of a CNT=3 frame
    step(1'b1, 8'h81);
    step(1'b1, 8'h02);
    step(1'b1, 8'h03);
    step(1'b1, 8'h44);
    chk("mid_wr", 32'(prog_data), 32'h44);
    reset = 1'b1;
    step(1'b1, 8'h55);
    chk("mid_rst_hdr", 32'(prog_header), 0);
    chk("mid_rst_nid", 32'(neuron_id), 0);
    chk("mid_rst_data", 32'(prog_data), 0);
    chk("mid_rst_hold", 32'(hold), 0);
    chk("mid_rst_err", 32'(err), 0);
    chk("mid_rst_done", 32'(done), 0);
    reset = 1'b0;
    err_m = 1'b0;
    last_nid_m = '0;
    step(1'b0, 8'h00);
    chk("mid_rel_hdr", 32'(prog_header), 0);
    d = '{8'h01, 8'h02, 8'h03};
    run_frame(make_frame(8'h86, 8'h07, 8'h03, d, 1'b0), 0, 1);

`ifdef PROG_CHECKSUM_EN
    q = '{8'h81, 8'h00, 8'h01, 8'h5A, 8'hDA};
    run_frame(q, 0, 0);
    q = '{8'h81, 8'h00, 8'h01, 8'h5A, 8'h00};
    run_frame(q, 0, 0);
`endif

    // Maximum count, auto-increment wraps many times
    d = {};
    for (int i = 0; i < 255; i++) d.push_back(8'($urandom));
    run_frame(make_frame(8'h87, 8'h03, 8'hFF, d, 1'b0), 0, 0);

    // Random frames, including malformed ones
    for (int i = 0; i < 40; i++) begin
      r   = $urandom_range(99, 0);
      op  = {1'($urandom), 4'b0000, 3'($urandom_range(7, 1))};
      nid = 8'($urandom_range(N - 1, 0));
      cnt = 8'($urandom_range(8, 1));
      bad = 1'b0;
      if (r < 8) begin
        if ($urandom_range(1, 0) == 1) op[2:0] = 3'd0;
        else op[6:3] = 4'($urandom_range(15, 1));
      end else if (r < 16) begin
        nid = 8'($urandom_range(255, N));
      end else if (r < 24) begin
        cnt = 8'd0;
      end else if (r < 34) begin
        bad = 1'b1;
      end
      d = {};
      for (int k = 0; k < int'(cnt); k++) d.push_back(8'($urandom));
      run_frame(make_frame(op, nid, cnt, d, bad), 0, 2);
    end

    chk("final_err", 32'(err), 32'(err_m));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
